// File: rtl/ws2811_receiver_if.sv
// rtl/ws2811_receiver_if.sv - decoded pixel/frame output bundle of the WS2811 receiver
// The receiver drives it through the master modport; consumers attach to slave.
interface ws2811_receiver_if #(
  parameter int INDEX_W = 10
);
  logic [23:0]        pixelOUT;
  logic               pixelValidOUT;
  logic [INDEX_W-1:0] pixelIndexOUT;
  logic               frameDoneOUT;
  logic               errorOUT;
  logic               busyOUT;

  modport master (
    output pixelOUT,
    output pixelValidOUT,
    output pixelIndexOUT,
    output frameDoneOUT,
    output errorOUT,
    output busyOUT
  );

  modport slave (
    input pixelOUT,
    input pixelValidOUT,
    input pixelIndexOUT,
    input frameDoneOUT,
    input errorOUT,
    input busyOUT
  );
endinterface

// File: rtl/ws2811_receiver.sv
// rtl/ws2811_receiver.sv - WS2811 single-wire decoder producing 24-bit pixels and frame strobes
// Optional colour-order unswap on completed pixels: define WS2811_RX_UNSWAP_EN.
module ws2811_receiver #(
  parameter int BIT_THRESHOLD = 21,
  parameter int MIN_HIGH      = 5,
  parameter int HIGH_TIMEOUT  = 60,
  parameter int RESET_CYCLES  = 2500,
  parameter int INDEX_W       = 10
) (
  input  logic              clockIN,
  input  logic              resetIN,
  input  logic              serialIN,
  input  logic [2:0]        swapIN,
  ws2811_receiver_if.master pix
);
  localparam int CW = $clog2(RESET_CYCLES + 1);

  // cnt_q lags the synchronized line by one cycle: at a falling edge the
  // finished high lasted cnt_q+1 cycles, and while a level persists it has
  // lasted cnt_q+2 cycles, so every limit below is pre-adjusted.
  localparam logic [CW-1:0] CNT_MAX  = CW'(RESET_CYCLES);
  localparam logic [CW-1:0] GAP_LAST = CW'(RESET_CYCLES - 2);
  localparam logic [CW-1:0] TMO_LAST = CW'(HIGH_TIMEOUT - 1);
  localparam logic [CW-1:0] MIN_LAST = CW'(MIN_HIGH - 1);
  localparam logic [CW-1:0] THR_LAST = CW'(BIT_THRESHOLD - 1);
  localparam logic [INDEX_W-1:0] IDX_MAX = '1;

  typedef enum logic [1:0] {
    WAIT_GAP = 2'd0,
    IDLE     = 2'd1,
    HIGH     = 2'd2,
    LOW      = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic               sync1_q, sync2_q, sync3_q;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [22:0]        shift_q, shift_d;
  logic [4:0]         bit_cnt_q, bit_cnt_d;
  logic               any_bit_q, any_bit_d;
  logic [INDEX_W-1:0] idx_q, idx_d;
  logic [23:0]        pixel_q, pixel_d;
  logic               pixel_valid_q, pixel_valid_d;
  logic [INDEX_W-1:0] pixel_index_q, pixel_index_d;
  logic               frame_done_q, frame_done_d;
  logic               error_q, error_d;

  logic rise, fall;
  logic fall_in_high, glitch, bit_ok, bit_val, complete;
  logic timeout, gap_low, gap_wait;
  logic [23:0] raw_word, out_word;

  assign rise = sync2_q & ~sync3_q;
  assign fall = ~sync2_q & sync3_q;

  always_comb begin
    cnt_d = cnt_q;
    if (rise || fall) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign fall_in_high = (state_q == HIGH) && fall;
  assign glitch       = fall_in_high && (cnt_q < MIN_LAST);
  assign bit_ok       = fall_in_high && !glitch;
  assign bit_val      = (cnt_q >= THR_LAST);
  assign complete     = bit_ok && (bit_cnt_q == 5'd23);
  assign timeout      = (state_q == HIGH) && sync2_q && (cnt_q >= TMO_LAST);
  assign gap_low      = (state_q == LOW) && !sync2_q && (cnt_q == GAP_LAST);
  // The edge-cycle guard keeps a stale saturated count from ending the gap early.
  assign gap_wait     = (state_q == WAIT_GAP) && !sync2_q && !sync3_q && (cnt_q >= GAP_LAST);

  assign raw_word = {shift_q, bit_val};

`ifdef WS2811_RX_UNSWAP_EN
  always_comb begin
    out_word = raw_word;
    case (swapIN)
      3'd1:    out_word = {raw_word[23:16], raw_word[7:0],   raw_word[15:8]};
      3'd2:    out_word = {raw_word[7:0],   raw_word[15:8],  raw_word[23:16]};
      3'd3:    out_word = {raw_word[15:8],  raw_word[7:0],   raw_word[23:16]};
      3'd4:    out_word = {raw_word[7:0],   raw_word[23:16], raw_word[15:8]};
      3'd5:    out_word = {raw_word[15:8],  raw_word[23:16], raw_word[7:0]};
      default: out_word = raw_word;
    endcase
  end
`else
  logic unused_swap;
  assign unused_swap = ^swapIN;
  assign out_word    = raw_word;
`endif

  always_ff @(posedge clockIN) begin
    if (resetIN) begin
      state_q       <= WAIT_GAP;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      sync3_q       <= 1'b0;
      cnt_q         <= '0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      any_bit_q     <= 1'b0;
      idx_q         <= '0;
      pixel_q       <= '0;
      pixel_valid_q <= 1'b0;
      pixel_index_q <= '0;
      frame_done_q  <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= serialIN;
      sync2_q       <= sync1_q;
      sync3_q       <= sync2_q;
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      any_bit_q     <= any_bit_d;
      idx_q         <= idx_d;
      pixel_q       <= pixel_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_index_q <= pixel_index_d;
      frame_done_q  <= frame_done_d;
      error_q       <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_GAP: if (gap_wait) state_d = IDLE;
      IDLE:     if (rise) state_d = HIGH;
      HIGH: begin
        if (timeout) begin
          state_d = WAIT_GAP;
        end else if (fall) begin
          state_d = LOW;
        end
      end
      LOW: begin
        if (rise) begin
          state_d = HIGH;
        end else if (gap_low) begin
          state_d = IDLE;
        end
      end
      default: state_d = WAIT_GAP;
    endcase
  end

  always_comb begin
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    any_bit_d     = any_bit_q;
    idx_d         = idx_q;
    pixel_d       = pixel_q;
    pixel_valid_d = 1'b0;
    pixel_index_d = pixel_index_q;
    frame_done_d  = 1'b0;
    error_d       = 1'b0;

    if (glitch) begin
      error_d = 1'b1;
    end

    if (bit_ok) begin
      any_bit_d = 1'b1;
      if (complete) begin
        pixel_d       = out_word;
        pixel_valid_d = 1'b1;
        pixel_index_d = idx_q;
        shift_d       = '0;
        bit_cnt_d     = '0;
        if (idx_q != IDX_MAX) begin
          idx_d = idx_q + 1'b1;
        end
      end else begin
        shift_d   = {shift_q[21:0], bit_val};
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end

    if (timeout) begin
      error_d   = 1'b1;
      shift_d   = '0;
      bit_cnt_d = '0;
      any_bit_d = 1'b0;
    end

    // A gap ending with leftover bits is a truncated pixel: report and drop it.
    if (gap_low) begin
      frame_done_d = any_bit_q;
      error_d      = (bit_cnt_q != 5'd0);
      shift_d      = '0;
      bit_cnt_d    = '0;
      any_bit_d    = 1'b0;
      idx_d        = '0;
    end

    if (gap_wait) begin
      any_bit_d = 1'b0;
      idx_d     = '0;
    end
  end

  assign pix.pixelOUT      = pixel_q;
  assign pix.pixelValidOUT = pixel_valid_q;
  assign pix.pixelIndexOUT = pixel_index_q;
  assign pix.frameDoneOUT  = frame_done_q;
  assign pix.errorOUT      = error_q;
  assign pix.busyOUT       = (state_q == HIGH) || (state_q == LOW);
endmodule

// File: tb/tb_ws2811_receiver.sv
// tb/tb_ws2811_receiver.sv - self-checking bench for ws2811_receiver
// Drives pulse trains, records strobes, and compares against expected pixel lists.
module tb_ws2811_receiver;
  localparam int GAP = 2520;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ser = 1'b0;
  logic [2:0] swap = 3'd0;

  always #5 clk = ~clk;

  ws2811_receiver_if #(.INDEX_W(10)) pif ();

  ws2811_receiver #(
    .BIT_THRESHOLD(21),
    .MIN_HIGH(5),
    .HIGH_TIMEOUT(60),
    .RESET_CYCLES(2500),
    .INDEX_W(10)
  ) dut (
    .clockIN(clk),
    .resetIN(rst),
    .serialIN(ser),
    .swapIN(swap),
    .pix(pif)
  );

  typedef struct {
    logic [23:0] word;
    int          idx;
  } vec_t;

  typedef struct {
    logic [2:0]  code;
    logic [23:0] exp_word;
  } swap_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_fd, n_err, n_both, fd_cyc, last_fall_cyc;
  logic [23:0] got_pix[$];
  int          got_idx[$];
  logic [23:0] exp_pix[$];
  int          exp_idx[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (pif.pixelValidOUT === 1'b1) begin
      got_pix.push_back(pif.pixelOUT);
      got_idx.push_back(int'(pif.pixelIndexOUT));
    end
    if (pif.frameDoneOUT === 1'b1) begin
      n_fd++;
      fd_cyc = cyc;
    end
    if (pif.errorOUT === 1'b1) n_err++;
    if (pif.frameDoneOUT === 1'b1 && pif.errorOUT === 1'b1) n_both++;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    ser = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input int h, input int l);
    hold(1'b1, h);
    last_fall_cyc = cyc;
    hold(1'b0, l);
  endtask

  task automatic send_std(input logic b);
    if (b) send_bit(30, 32);
    else   send_bit(12, 50);
  endtask

  task automatic send_bits(input logic [23:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) send_std(w[i]);
  endtask

  task automatic expect_pix(input logic [23:0] w, input int idx);
    exp_pix.push_back(w);
    exp_idx.push_back(idx);
  endtask

  task automatic clear_mon();
    got_pix.delete();
    got_idx.delete();
    exp_pix.delete();
    exp_idx.delete();
    n_fd   = 0;
    n_err  = 0;
    n_both = 0;
  endtask

  task automatic compare(input string name, input int efd, input int eerr, input int eboth);
    chk({name, "_npix"}, got_pix.size(), exp_pix.size());
    for (int i = 0; i < exp_pix.size() && i < got_pix.size(); i++) begin
      chk({name, "_pix"}, got_pix[i], exp_pix[i]);
      chk({name, "_idx"}, got_idx[i], exp_idx[i]);
    end
    chk({name, "_framedone"}, n_fd, efd);
    chk({name, "_error"}, n_err, eerr);
    chk({name, "_coincide"}, n_both, eboth);
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, "_pixel"}, pif.pixelOUT, 0);
    chk({name, "_valid"}, pif.pixelValidOUT, 0);
    chk({name, "_index"}, pif.pixelIndexOUT, 0);
    chk({name, "_fd"}, pif.frameDoneOUT, 0);
    chk({name, "_err"}, pif.errorOUT, 0);
    chk({name, "_busy"}, pif.busyOUT, 0);
  endtask

  vec_t  vt[3];
  swap_t st[4];

  initial begin
    int d;
    logic [23:0] w;
    int npix, nglitch, h;

    vt[0] = '{24'h010203, 0};
    vt[1] = '{24'hFF0000, 1};
    vt[2] = '{24'h00FF00, 2};
`ifdef WS2811_RX_UNSWAP_EN
    st[0] = '{3'd3, 24'h223311};
    st[1] = '{3'd4, 24'h331122};
    st[2] = '{3'd2, 24'h332211};
    st[3] = '{3'd0, 24'h112233};
`else
    st[0] = '{3'd3, 24'h112233};
    st[1] = '{3'd4, 24'h112233};
    st[2] = '{3'd2, 24'h112233};
    st[3] = '{3'd0, 24'h112233};
`endif

    rst = 1'b1;
    ser = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b0;
    clear_mon();

    // Leading gap then a single pixel.
    hold(1'b0, GAP);
    send_bits(24'hA5C33C, 23, 0);
    expect_pix(24'hA5C33C, 0);
    hold(1'b0, GAP);
    compare("single", 1, 0, 0);

    // Table: three pixels in one frame, then gap timing.
    clear_mon();
    for (int i = 0; i < 3; i++) begin
      send_bits(vt[i].word, 23, 0);
      expect_pix(vt[i].word, vt[i].idx);
    end
    hold(1'b0, GAP);
    compare("three", 1, 0, 0);
    d = fd_cyc - last_fall_cyc;
    checks++;
    if (d < 2500 || d > 2505) begin
      errors++;
      $display("FAIL fd_delay got=%0d exp=2500..2505", d);
    end

    clear_mon();
    send_bits(24'h123456, 23, 0);
    expect_pix(24'h123456, 0);
    hold(1'b0, GAP);
    compare("idx_restart", 1, 0, 0);

    // Colour-order table, swap code changed between pixels.
    clear_mon();
    for (int i = 0; i < 4; i++) begin
      swap = st[i].code;
      send_bits(24'h112233, 23, 0);
      expect_pix(st[i].exp_word, i);
    end
    hold(1'b0, GAP);
    swap = 3'd0;
    compare("swap", 1, 0, 0);

    // Stream already mid-bit at reset release: nothing until a real gap.
    rst = 1'b1;
    ser = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_mon();
    hold(1'b1, 20);
    hold(1'b0, 50);
    send_bits(24'hDEADBE, 23, 0);
    chk("nogap_npix_early", got_pix.size(), 0);
    hold(1'b0, GAP);
    send_bits(24'h5A5A5A, 23, 0);
    expect_pix(24'h5A5A5A, 0);
    hold(1'b0, GAP);
    compare("nogap", 1, 0, 0);

    // 3-cycle glitch in the middle of a pixel.
    clear_mon();
    send_bits(24'hC3A596, 23, 14);
    send_bit(3, 40);
    send_bits(24'hC3A596, 13, 0);
    expect_pix(24'hC3A596, 0);
    hold(1'b0, GAP);
    compare("glitch", 1, 1, 0);

    // Pulse-width boundaries: 5/20 decode as 0, 21/60 decode as 1.
    clear_mon();
    w = 24'h9C3E71;
    for (int i = 23; i >= 0; i--) begin
      if (w[i]) send_bit((i % 2) ? 21 : 60, 30);
      else      send_bit((i % 2) ? 5 : 20, 30);
    end
    expect_pix(w, 0);
    hold(1'b0, GAP);
    compare("bounds", 1, 0, 0);

    // Stuck-high line: error, then bits ignored until a gap.
    clear_mon();
    hold(1'b1, 61);
    hold(1'b0, 10);
    chk("timeout_busy", pif.busyOUT, 0);
    hold(1'b0, 90);
    send_bits(24'h777777, 23, 16);
    hold(1'b0, GAP);
    compare("timeout", 0, 1, 0);

    // Truncated pixel at the gap.
    clear_mon();
    send_bits(24'h3FF000, 23, 14);
    hold(1'b0, GAP);
    compare("partial", 1, 1, 1);

    // Reset in the middle of a pixel.
    clear_mon();
    send_bits(24'hF0F0F0, 23, 12);
    hold(1'b1, 10);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_idle_outputs("midreset");
    ser = 1'b0;
    rst = 1'b0;
    hold(1'b0, GAP);
    send_bits(24'h13579B, 23, 0);
    expect_pix(24'h13579B, 0);
    hold(1'b0, GAP);
    compare("midreset", 1, 0, 0);

    // Random frames: random words, random legal timings, occasional glitches.
    for (int f = 0; f < 3; f++) begin
      clear_mon();
      npix = $urandom_range(1, 3);
      nglitch = 0;
      for (int p = 0; p < npix; p++) begin
        w = 24'($urandom);
        for (int i = 23; i >= 0; i--) begin
          if ($urandom_range(0, 19) == 0) begin
            send_bit($urandom_range(1, 4), $urandom_range(5, 40));
            nglitch++;
          end
          h = w[i] ? $urandom_range(21, 60) : $urandom_range(5, 20);
          send_bit(h, $urandom_range(5, 40));
        end
        expect_pix(w, p);
      end
      hold(1'b0, GAP);
      compare("random", 1, nglitch, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
